// File: rtl/img_proc_pkg.sv
// Shared image-processing definitions: default geometry, pixel width and
// the frame-tracking state encoding used by the streaming pixel operators.
package img_proc_pkg;

    localparam int unsigned DATA_W     = 10;
    localparam int unsigned IMG_WIDTH  = 640;
    localparam int unsigned IMG_HEIGHT = 480;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    // Counter width for a range of n positions, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Column/row position of the pixel being accepted, with border flags.
// A restart treats the current pixel as (0,0) and advances from there.
module pixel_position_counter #(
    parameter int unsigned IMG_WIDTH  = img_proc_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = img_proc_pkg::IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    input  logic restart,
    output logic at_origin,
    output logic first_col,
    output logic last_col,
    output logic first_row,
    output logic last_row
);
    import img_proc_pkg::*;

    localparam int unsigned CW = cnt_w(IMG_WIDTH);
    localparam int unsigned RW = cnt_w(IMG_HEIGHT);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Position of the pixel presented this cycle; a restart pins it to the origin.
    always_comb begin
        col = restart ? '0 : col_q;
        row = restart ? '0 : row_q;
    end

    assign at_origin = (col_q == '0) && (row_q == '0);
    assign first_col = (col == '0);
    assign last_col  = (col == CW'(IMG_WIDTH - 1));
    assign first_row = (row == '0);
    assign last_row  = (row == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (advance) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row + 1'b1;
            end else begin
                col_q <= col + 1'b1;
                row_q <= row;
            end
        end
    end

endmodule

// File: rtl/binarize_stream.sv
// Streaming threshold binarizer: two-stage pipeline with frame tracking,
// frame-synchronous threshold update and all-ones border forcing.
module binarize_stream #(
    parameter int unsigned       DATA_W      = img_proc_pkg::DATA_W,
    parameter int unsigned       IMG_WIDTH   = img_proc_pkg::IMG_WIDTH,
    parameter int unsigned       IMG_HEIGHT  = img_proc_pkg::IMG_HEIGHT,
    parameter logic [DATA_W-1:0] THR_DEFAULT = 10'd512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    input  logic              thr_wr,
    input  logic [DATA_W-1:0] thr_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              err_line
);
    import img_proc_pkg::*;

    state_t            state;
    logic [DATA_W-1:0] thr_shadow;
    logic [DATA_W-1:0] thr_active;
    logic [DATA_W-1:0] thr_use;

    logic accept;
    logic restart;
    logic at_origin;
    logic first_col;
    logic last_col;
    logic first_row;
    logic last_row;
    logic border;
    logic last_px;

    logic s1_valid;
    logic s1_sof;
    logic s1_fg;
    logic s1_border;

    // Pixels are taken only inside a frame or when they open one.
    assign accept  = in_valid && (in_sof || (state == ACTIVE));
    assign restart = accept && in_sof;
    assign border  = first_col || last_col || first_row || last_row;
    assign last_px = last_col && last_row;

    // The frame-opening pixel already sees the newly committed threshold.
    assign thr_use = !restart ? thr_active : (thr_wr ? thr_in : thr_shadow);

    pixel_position_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (accept),
        .restart  (restart),
        .at_origin(at_origin),
        .first_col(first_col),
        .last_col (last_col),
        .first_row(first_row),
        .last_row (last_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            thr_shadow <= THR_DEFAULT;
            thr_active <= THR_DEFAULT;
            err_line   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_fg      <= 1'b0;
            s1_border  <= 1'b0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_data   <= '0;
        end else begin
            if (thr_wr) begin
                thr_shadow <= thr_in;
            end
            if (restart) begin
                thr_active <= thr_use;
            end
            if (restart && (state == ACTIVE) && !at_origin) begin
                err_line <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (restart) begin
                        state <= last_px ? DONE : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept && last_px) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (in_valid) begin
                        state <= in_sof ? (last_px ? DONE : ACTIVE) : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            s1_valid  <= accept;
            s1_sof    <= restart;
            s1_fg     <= (in_data >= thr_use);
            s1_border <= border;

            out_valid <= s1_valid;
            out_sof   <= s1_valid && s1_sof;
            out_data  <= (s1_valid && (s1_fg || s1_border)) ? '1 : '0;
        end
    end

endmodule

// File: tb/tb_binarize_stream.sv
// Directed bench for binarize_stream on an 8x4 image with a frame-level
// reference model and hand-computed spot checks.
module tb_binarize_stream;

    localparam int TW = 8;
    localparam int TH = 4;
    localparam int NPX = TW * TH;
    localparam int NC = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [9:0] in_data = '0;
    logic       thr_wr = 1'b0;
    logic [9:0] thr_in = '0;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_sof;
    logic       err_line;

    binarize_stream #(
        .DATA_W     (10),
        .IMG_WIDTH  (TW),
        .IMG_HEIGHT (TH),
        .THR_DEFAULT(10'd512)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_data  (in_data),
        .thr_wr   (thr_wr),
        .thr_in   (thr_in),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sof  (out_sof),
        .err_line (err_line)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: frame mode (0 waiting, 1 in frame, 2 frame complete),
    // pixel index within the frame, thresholds, sticky error.
    int  m_mode = 0;
    int  m_idx = 0;
    int  m_thr = 512;
    int  m_sh = 512;
    bit  m_err = 1'b0;
    bit  exp_v [NC];
    bit  exp_s [NC];
    logic [9:0] exp_d [NC];

    logic [9:0] obs_d [$];
    bit         obs_s [$];
    int         obs_c [$];

    always @(posedge clk) begin
        int  x;
        int  y;
        bit  acc;
        bit  fg;
        int  slot;
        slot = (cyc + 2) % NC;
        if (!rst_n) begin
            m_mode = 0;
            m_idx = 0;
            m_thr = 512;
            m_sh = 512;
            m_err = 1'b0;
            exp_v[(cyc + 1) % NC] = 1'b0;
            exp_v[slot] = 1'b0;
        end else begin
            acc = in_valid && (in_sof || m_mode == 1);
            if (in_valid && !in_sof && m_mode == 2) m_mode = 0;
            if (acc) begin
                if (in_sof) begin
                    if (m_mode == 1 && m_idx != 0) m_err = 1'b1;
                    m_idx = 0;
                    m_thr = thr_wr ? int'(thr_in) : m_sh;
                end
                x = m_idx % TW;
                y = m_idx / TW;
                fg = (int'(in_data) >= m_thr) || x == 0 || x == TW - 1 || y == 0 || y == TH - 1;
                exp_v[slot] = 1'b1;
                exp_s[slot] = in_sof;
                exp_d[slot] = fg ? 10'h3ff : 10'h000;
                m_idx++;
                if (m_idx == NPX) begin
                    m_mode = 2;
                    m_idx = 0;
                end else begin
                    m_mode = 1;
                end
            end
            if (thr_wr) m_sh = int'(thr_in);
        end
        cyc++;
    end

    // Per-cycle comparison against the model, plus capture of accepted outputs.
    always @(negedge clk) begin
        int k;
        k = cyc % NC;
        if (!rst_n) begin
            n_cmp++;
            if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_data !== 10'h000 || err_line !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs @%0d: got v=%b s=%b d=%h e=%b required all 0",
                         cyc, out_valid, out_sof, out_data, err_line);
            end
        end else begin
            n_cmp++;
            if (out_valid !== exp_v[k]) begin
                n_bad++;
                $display("FAIL out_valid @%0d: got %b required %b", cyc, out_valid, exp_v[k]);
            end else if (exp_v[k]) begin
                n_cmp++;
                if (out_data !== exp_d[k] || out_sof !== exp_s[k]) begin
                    n_bad++;
                    $display("FAIL out_data/sof @%0d: got %h/%b required %h/%b",
                             cyc, out_data, out_sof, exp_d[k], exp_s[k]);
                end
            end
            n_cmp++;
            if (err_line !== m_err) begin
                n_bad++;
                $display("FAIL err_line @%0d: got %b required %b", cyc, err_line, m_err);
            end
            if (out_valid === 1'b1) begin
                obs_d.push_back(out_data);
                obs_s.push_back(out_sof);
                obs_c.push_back(cyc);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [9:0] d,
                         input logic w, input logic [9:0] t);
        @(posedge clk);
        #3;
        in_valid = v;
        in_sof = s;
        in_data = d;
        thr_wr = w;
        thr_in = t;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
    endtask

    logic [9:0] px [NPX];
    int c9;

    task automatic send_frame(input bit gaps, input int wr_at, input logic [9:0] wr_val);
        for (int i = 0; i < NPX; i++) begin
            drive(1'b1, i == 0, px[i], i == wr_at, wr_val);
            if (i == 9) c9 = cyc;
            if (gaps) drive(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        end
        idle(1);
    endtask

    task automatic clear_px();
        for (int i = 0; i < NPX; i++) px[i] = 10'h000;
    endtask

    initial begin
        int b;
        int b2;
        int cnt;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        lit("reset_out_valid", {31'd0, out_valid}, 0);
        lit("reset_out_data", {22'd0, out_data}, 0);
        lit("reset_err_line", {31'd0, err_line}, 0);

        // All-zero frame, then a stray non-sof pixel after the frame.
        clear_px();
        b = obs_d.size();
        send_frame(1'b0, -1, 10'h000);
        drive(1'b1, 1'b0, 10'h3ff, 1'b0, 10'h000);
        idle(4);
        lit("zero_frame_count", obs_d.size() - b, NPX);
        lit("zero_corner", {22'd0, obs_d[b]}, 10'h3ff);
        lit("zero_interior", {22'd0, obs_d[b + 9]}, 10'h000);
        lit("zero_last", {22'd0, obs_d[b + 31]}, 10'h3ff);
        cnt = 0;
        for (int i = 0; i < NPX; i++) if (obs_d[b + i] == 10'h000) cnt++;
        lit("zero_interior_count", cnt, 12);
        cnt = 0;
        for (int i = 0; i < NPX; i++) if (obs_s[b + i]) cnt++;
        lit("zero_sof_count", cnt, 1);
        lit("zero_err", {31'd0, err_line}, 0);

        // Threshold 512: 600 foreground, 511 background, latency 2.
        clear_px();
        px[9] = 10'd600;
        px[10] = 10'd511;
        b = obs_d.size();
        send_frame(1'b0, -1, 10'h000);
        idle(3);
        lit("thr512_600", {22'd0, obs_d[b + 9]}, 10'h3ff);
        lit("thr512_511", {22'd0, obs_d[b + 10]}, 10'h000);
        lit("latency", obs_c[b + 9] - c9, 2);

        // Mid-frame threshold write only takes effect on the next frame.
        clear_px();
        px[9] = 10'd200;
        px[10] = 10'd99;
        b = obs_d.size();
        send_frame(1'b0, 5, 10'd100);
        idle(3);
        lit("midframe_thr_200", {22'd0, obs_d[b + 9]}, 10'h000);
        b = obs_d.size();
        send_frame(1'b0, -1, 10'h000);
        idle(3);
        lit("nextframe_thr_200", {22'd0, obs_d[b + 9]}, 10'h3ff);
        lit("nextframe_thr_99", {22'd0, obs_d[b + 10]}, 10'h000);

        // Threshold write coincident with sof applies to that frame.
        clear_px();
        px[9] = 10'd250;
        px[10] = 10'd300;
        b = obs_d.size();
        send_frame(1'b0, 0, 10'd300);
        idle(3);
        lit("sofwr_250", {22'd0, obs_d[b + 9]}, 10'h000);
        lit("sofwr_300", {22'd0, obs_d[b + 10]}, 10'h3ff);

        // Early sof at pixel index 5 restarts the frame and flags the error.
        b = obs_d.size();
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 10'h000, 1'b0, 10'h000);
        clear_px();
        px[9] = 10'd400;
        send_frame(1'b0, -1, 10'h000);
        idle(3);
        lit("early_sof_err", {31'd0, err_line}, 1);
        lit("early_sof_count", obs_d.size() - b, 5 + NPX);
        lit("early_sof_restart_pix9", {22'd0, obs_d[b + 5 + 9]}, 10'h3ff);
        lit("early_sof_restart_pix10", {22'd0, obs_d[b + 5 + 10]}, 10'h000);
        lit("early_sof_restart_sof", {31'd0, obs_s[b + 5]}, 1);

        // Gapped input must reproduce the gapless output.
        for (int i = 0; i < NPX; i++) px[i] = 10'((i * 37) % 1024);
        b = obs_d.size();
        send_frame(1'b0, -1, 10'h000);
        idle(3);
        b2 = obs_d.size();
        send_frame(1'b1, -1, 10'h000);
        idle(3);
        lit("gap_count", obs_d.size() - b2, NPX);
        cnt = 0;
        for (int i = 0; i < NPX; i++) if (obs_d[b + i] != obs_d[b2 + i]) cnt++;
        lit("gap_data_diffs", cnt, 0);
        cnt = 0;
        for (int i = 0; i < NPX - 1; i++) if (obs_c[b2 + i + 1] - obs_c[b2 + i] != 2) cnt++;
        lit("gap_spacing", cnt, 0);

        // Reset in the middle of a frame.
        clear_px();
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 10'h000, 1'b0, 10'h000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        #1;
        lit("midreset_out_valid", {31'd0, out_valid}, 0);
        lit("midreset_err", {31'd0, err_line}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        b = obs_d.size();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 10'h3ff, 1'b0, 10'h000);
        idle(4);
        lit("post_reset_discard", obs_d.size() - b, 0);
        px[9] = 10'd511;
        px[10] = 10'd512;
        b = obs_d.size();
        send_frame(1'b0, -1, 10'h000);
        idle(4);
        lit("post_reset_511", {22'd0, obs_d[b + 9]}, 10'h000);
        lit("post_reset_512", {22'd0, obs_d[b + 10]}, 10'h3ff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
